// File: rtl/pre_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : pre_if_stage
//  Purpose  : Pre-IF fetch sequencer. Issues one instruction-SRAM request at a
//             time, buffers the returned word and hands {adel, inst, pc} to IF.
//             Handles branch redirects after the delay slot, exception/eret
//             flushes with cancellation of the in-flight response, and
//             misaligned-pc address errors.
//             Optional: PRE_IF_PERF_CNT_EN adds fetch_cnt / cancel_cnt.
//  Revision : 1.0 - initial release
// ============================================================================
module pre_if_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        fs_allowin,
    input  logic [32:0] br_bus,
    input  logic        ex_from_ws,
    input  logic        eret_from_ws,
    input  logic [31:0] cp0_epc,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    output logic        ps_to_fs_valid,
    output logic [64:0] ps_to_fs_bus
`ifdef PRE_IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_cnt,
    output logic [31:0] cancel_cnt
`endif
);

    localparam logic [31:0] c_RESET_PC = 32'hbfc0_0000;
    localparam logic [31:0] c_EX_PC    = 32'hbfc0_0380;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t      r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_addr, w_addr_nxt;
    logic        r_br_pending, w_br_pending_nxt;
    logic [31:0] r_br_target, w_br_target_nxt;
    logic        r_cancel, w_cancel_nxt;
    logic [64:0] r_bus, w_bus_nxt;
    logic        r_valid;

    logic        w_flush;
    logic [31:0] w_flush_pc;
    logic        w_br_pend;
    logic [31:0] w_br_tgt;
    logic [31:0] w_seq_pc;
    logic        w_launch;
    logic [31:0] w_launch_pc;

    assign w_flush    = ex_from_ws | eret_from_ws;
    assign w_flush_pc = ex_from_ws ? c_EX_PC : cp0_epc;
    // A branch arriving in the same cycle the delay slot leaves must still redirect.
    assign w_br_pend  = r_br_pending | br_bus[32];
    assign w_br_tgt   = br_bus[32] ? br_bus[31:0] : r_br_target;
    assign w_seq_pc   = w_br_pend ? w_br_tgt : r_pc + 32'd4;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_addr_nxt       = r_addr;
        w_cancel_nxt     = r_cancel;
        w_bus_nxt        = r_bus;
        w_br_pending_nxt = w_flush ? 1'b0 : w_br_pend;
        w_br_target_nxt  = w_br_tgt;
        w_launch         = 1'b0;
        w_launch_pc      = r_pc;

        case (r_state)
            IDLE: begin
                w_launch    = 1'b1;
                w_launch_pc = w_flush ? w_flush_pc : r_pc;
            end
            REQ: begin
                // A flush cannot retract the address already on the bus; it is
                // completed and its response marked for discard.
                if (w_flush) begin
                    w_pc_nxt     = w_flush_pc;
                    w_cancel_nxt = 1'b1;
                end
                if (inst_sram_addr_ok) begin
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (inst_sram_data_ok) begin
                    w_cancel_nxt = 1'b0;
                    if (w_flush || r_cancel) begin
                        w_launch    = 1'b1;
                        w_launch_pc = w_flush ? w_flush_pc : r_pc;
                    end else begin
                        w_bus_nxt   = {1'b0, inst_sram_rdata, r_pc};
                        w_state_nxt = HOLD;
                    end
                end else if (w_flush) begin
                    w_pc_nxt     = w_flush_pc;
                    w_cancel_nxt = 1'b1;
                end
            end
            HOLD: begin
                if (w_flush) begin
                    w_bus_nxt   = '0;
                    w_launch    = 1'b1;
                    w_launch_pc = w_flush_pc;
                end else if (fs_allowin) begin
                    w_launch         = 1'b1;
                    w_launch_pc      = w_seq_pc;
                    w_br_pending_nxt = 1'b0;
                end
            end
            default: w_state_nxt = REQ;
        endcase

        // Misaligned fetch pc never reaches the SRAM; it is presented as an
        // address-error instruction instead.
        if (w_launch) begin
            w_pc_nxt   = w_launch_pc;
            w_addr_nxt = w_launch_pc;
            if (w_launch_pc[1:0] != 2'b00) begin
                w_state_nxt = HOLD;
                w_bus_nxt   = {1'b1, 32'h0, w_launch_pc};
            end else begin
                w_state_nxt = REQ;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= REQ;
            r_pc         <= c_RESET_PC;
            r_addr       <= c_RESET_PC;
            r_br_pending <= 1'b0;
            r_br_target  <= 32'h0;
            r_cancel     <= 1'b0;
            r_bus        <= '0;
            r_valid      <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_addr       <= w_addr_nxt;
            r_br_pending <= w_br_pending_nxt;
            r_br_target  <= w_br_target_nxt;
            r_cancel     <= w_cancel_nxt;
            r_bus        <= w_bus_nxt;
            r_valid      <= (w_state_nxt == HOLD);
        end
    end

    assign inst_sram_req   = (r_state == REQ);
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_addr  = r_addr;
    assign inst_sram_wdata = 32'h0;
    assign ps_to_fs_valid  = r_valid;
    assign ps_to_fs_bus    = r_bus;

`ifdef PRE_IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_cancel_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt  <= 32'h0;
            r_cancel_cnt <= 32'h0;
        end else begin
            if (r_state == REQ && inst_sram_addr_ok) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (r_state == WAIT && inst_sram_data_ok && (r_cancel || w_flush)) begin
                r_cancel_cnt <= r_cancel_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt  = r_fetch_cnt;
    assign cancel_cnt = r_cancel_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pre_if_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pre_if_stage
//  Purpose  : Directed self-checking bench for pre_if_stage: SRAM responder,
//             address/delivery scoreboard and per-cycle interface checks.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pre_if_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fs_allowin = 1'b0;
    logic [32:0] br_bus = '0;
    logic        ex_from_ws = 1'b0;
    logic        eret_from_ws = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;
    logic [31:0] inst_sram_rdata = '0;
    logic        ps_to_fs_valid;
    logic [64:0] ps_to_fs_bus;
`ifdef PRE_IF_PERF_CNT_EN
    logic [31:0] fetch_cnt;
    logic [31:0] cancel_cnt;
`endif

    pre_if_stage u_dut (
        .clk               (clk),
        .reset             (reset),
        .fs_allowin        (fs_allowin),
        .br_bus            (br_bus),
        .ex_from_ws        (ex_from_ws),
        .eret_from_ws      (eret_from_ws),
        .cp0_epc           (cp0_epc),
        .inst_sram_req     (inst_sram_req),
        .inst_sram_wr      (inst_sram_wr),
        .inst_sram_size    (inst_sram_size),
        .inst_sram_addr    (inst_sram_addr),
        .inst_sram_wdata   (inst_sram_wdata),
        .inst_sram_addr_ok (inst_sram_addr_ok),
        .inst_sram_data_ok (inst_sram_data_ok),
        .inst_sram_rdata   (inst_sram_rdata),
        .ps_to_fs_valid    (ps_to_fs_valid),
        .ps_to_fs_bus      (ps_to_fs_bus)
`ifdef PRE_IF_PERF_CNT_EN
        ,
        .fetch_cnt         (fetch_cnt),
        .cancel_cnt        (cancel_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n_deliv = 0;
    int extra_delay = 0;
    int stray_tok = 0;
    logic [31:0] exp_addr[$];
    logic [32:0] exp_del[$];

    // Instruction memory contents as a pure function of the word address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // SRAM responder: addr_ok in the request cycle, data_ok extra_delay cycles later.
    initial begin : responder
        logic        pend;
        int          cnt;
        int          stray_seen;
        logic [31:0] paddr;
        pend = 1'b0; cnt = 0; stray_seen = 0; paddr = '0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                inst_sram_addr_ok = 1'b0;
                inst_sram_data_ok = 1'b0;
                pend = 1'b0;
            end else begin
                if (inst_sram_addr_ok) begin
                    pend = 1'b1;
                    cnt  = extra_delay;
                end
                inst_sram_data_ok = 1'b0;
                inst_sram_addr_ok = 1'b0;
                if (pend) begin
                    if (cnt == 0) begin
                        inst_sram_data_ok = 1'b1;
                        inst_sram_rdata   = mem_word(paddr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
                if (stray_tok != stray_seen) begin
                    stray_seen = stray_tok;
                    inst_sram_data_ok = 1'b1;
                    inst_sram_rdata   = 32'hdead_beef;
                end else if (inst_sram_req && !pend && !inst_sram_data_ok) begin
                    inst_sram_addr_ok = 1'b1;
                    paddr = inst_sram_addr;
                end
            end
        end
    end

    // Per-cycle compare against the scoreboard queues and interface rules.
    initial begin : compare
        logic        prev_stall;
        logic [64:0] prev_bus;
        logic [31:0] a;
        logic [32:0] e;
        int          hs_model;
        prev_stall = 1'b0; prev_bus = '0; hs_model = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_stall = 1'b0;
                hs_model = 0;
            end else begin
                chk("const_outputs", {inst_sram_wr, inst_sram_size, inst_sram_wdata},
                    {1'b0, 2'b10, 32'h0});
                if (inst_sram_req && ps_to_fs_valid) begin
                    chk("req_valid_exclusive", 1'b1, 1'b0);
                end
                if (prev_stall) begin
                    chk("hold_stable", {ps_to_fs_valid, ps_to_fs_bus}, {1'b1, prev_bus});
                end
`ifdef PRE_IF_PERF_CNT_EN
                chk("fetch_cnt", fetch_cnt, hs_model);
`endif
                if (inst_sram_req && inst_sram_addr_ok) begin
                    if (exp_addr.size() == 0) begin
                        chk("unexpected_request", inst_sram_addr, 0);
                    end else begin
                        a = exp_addr.pop_front();
                        chk("request_addr", inst_sram_addr, a);
                    end
                    hs_model++;
                end
                if (ps_to_fs_valid && fs_allowin) begin
                    if (exp_del.size() == 0) begin
                        chk("unexpected_delivery", ps_to_fs_bus, 0);
                    end else begin
                        e = exp_del.pop_front();
                        chk("delivery", ps_to_fs_bus,
                            {e[32], (e[32] ? 32'h0 : mem_word(e[31:0])), e[31:0]});
                    end
                    n_deliv++;
                end
                prev_stall = ps_to_fs_valid && !fs_allowin && !ex_from_ws && !eret_from_ws;
                prev_bus   = ps_to_fs_bus;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_addr_hs(input logic [31:0] a);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (inst_sram_req && inst_sram_addr_ok && inst_sram_addr == a) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) chk("timeout_addr_hs", 0, a);
    endtask

    task automatic wait_deliv(input int target);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (n_deliv >= target) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) chk("timeout_delivery", n_deliv, target);
    endtask

    task automatic wait_valid();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ps_to_fs_valid) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        if (!found) chk("timeout_valid", 0, 1);
    endtask

    task automatic finish_scn(input string name);
        tick();
        chk(name, {exp_addr.size(), exp_del.size()}, 0);
        exp_addr.delete();
        exp_del.delete();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [64:0] b0;
        int base;

        // Reset state and first cycle after release
        repeat (3) tick();
        @(negedge clk);
        chk("reset_valid", ps_to_fs_valid, 1'b0);
        chk("reset_bus", ps_to_fs_bus, 65'h0);
        chk("reset_addr", inst_sram_addr, 32'hbfc0_0000);
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("first_cycle_req", {inst_sram_req, inst_sram_addr}, {1'b1, 32'hbfc0_0000});
        tick();

        // Sequential fetch with one-cycle latency
        exp_addr = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0008, 32'hbfc0_000c};
        exp_del  = '{{1'b0, 32'hbfc0_0000}, {1'b0, 32'hbfc0_0004}, {1'b0, 32'hbfc0_0008}};
        base = n_deliv;
        fs_allowin = 1'b1;
        wait_deliv(base + 3);
        fs_allowin = 1'b0;
        wait_valid();
        chk("held_0c_literal", ps_to_fs_bus, 65'h0_135bdbe0_bfc0000c);
        finish_scn("scn_sequential");

        // Branch while delay slot 0x..04 is in WAIT
        do_reset();
        exp_addr = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0100, 32'hbfc0_0104};
        exp_del  = '{{1'b0, 32'hbfc0_0000}, {1'b0, 32'hbfc0_0004}, {1'b0, 32'hbfc0_0100}};
        base = n_deliv;
        fs_allowin = 1'b1;
        wait_addr_hs(32'hbfc0_0004);
        tick();
        br_bus = {1'b1, 32'hbfc0_0100};
        tick();
        br_bus = '0;
        wait_deliv(base + 3);
        fs_allowin = 1'b0;
        wait_valid();
        finish_scn("scn_branch");

        // Exception in WAIT before data returns
        do_reset();
        extra_delay = 2;
        exp_addr = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0380, 32'hbfc0_0384};
        exp_del  = '{{1'b0, 32'hbfc0_0000}, {1'b0, 32'hbfc0_0380}};
        base = n_deliv;
        fs_allowin = 1'b1;
        wait_addr_hs(32'hbfc0_0004);
        tick();
        ex_from_ws = 1'b1;
        tick();
        ex_from_ws = 1'b0;
        wait_deliv(base + 2);
        fs_allowin = 1'b0;
        wait_valid();
`ifdef PRE_IF_PERF_CNT_EN
        chk("cancel_cnt_ex_wait", cancel_cnt, 32'd1);
        chk("fetch_cnt_ex_wait", fetch_cnt, 32'd4);
`endif
        extra_delay = 0;
        finish_scn("scn_ex_wait");

        // IF stall for 5 cycles in HOLD
        do_reset();
        exp_addr = '{32'hbfc0_0000, 32'hbfc0_0004};
        exp_del  = '{{1'b0, 32'hbfc0_0000}};
        wait_valid();
        b0 = ps_to_fs_bus;
        chk("held_00_literal", b0, 65'h0_1357dbe0_bfc00000);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_req", {inst_sram_req, ps_to_fs_valid}, {1'b0, 1'b1});
            chk("stall_bus", ps_to_fs_bus, b0);
        end
        fs_allowin = 1'b1;
        tick();
        fs_allowin = 1'b0;
        wait_valid();
        finish_scn("scn_stall");

        // eret to a misaligned epc
        do_reset();
        exp_addr = '{32'hbfc0_0000};
        exp_del  = '{{1'b1, 32'hbfc0_0202}};
        wait_valid();
        cp0_epc = 32'hbfc0_0202;
        eret_from_ws = 1'b1;
        tick();
        eret_from_ws = 1'b0;
        chk("adel_bus", ps_to_fs_bus, 65'h1_00000000_bfc00202);
        chk("adel_valid_noreq", {ps_to_fs_valid, inst_sram_req}, {1'b1, 1'b0});
        tick();
        fs_allowin = 1'b1;
        tick();
        fs_allowin = 1'b0;
        tick();
        chk("adel_next_noreq", {ps_to_fs_valid, inst_sram_req}, {1'b1, 1'b0});
        finish_scn("scn_eret_adel");

        // Exception and branch together, coinciding with data_ok
        do_reset();
        exp_addr = '{32'hbfc0_0000, 32'hbfc0_0004, 32'hbfc0_0380, 32'hbfc0_0384};
        exp_del  = '{{1'b0, 32'hbfc0_0000}, {1'b0, 32'hbfc0_0380}};
        base = n_deliv;
        fs_allowin = 1'b1;
        wait_addr_hs(32'hbfc0_0004);
        tick();
        ex_from_ws = 1'b1;
        br_bus = {1'b1, 32'hbfc0_0100};
        tick();
        ex_from_ws = 1'b0;
        br_bus = '0;
        wait_deliv(base + 2);
        fs_allowin = 1'b0;
        wait_valid();
`ifdef PRE_IF_PERF_CNT_EN
        chk("cancel_cnt_ex_br", cancel_cnt, 32'd1);
`endif
        finish_scn("scn_ex_and_branch");

        // Reset during WAIT, then a stray data_ok before any new request
        do_reset();
        exp_addr = '{32'hbfc0_0000};
        fs_allowin = 1'b1;
        wait_addr_hs(32'hbfc0_0000);
        tick();
        exp_addr.push_back(32'hbfc0_0000);
        exp_addr.push_back(32'hbfc0_0004);
        exp_del.push_back({1'b0, 32'hbfc0_0000});
        base = n_deliv;
        stray_tok++;
        do_reset();
        wait_deliv(base + 1);
        fs_allowin = 1'b0;
        wait_valid();
        finish_scn("scn_reset_midop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
